// File: rtl/mult_share_ctrl.sv
// Two-requester round-robin front end for a single iterative shift-add unsigned multiplier.
// Optional feature MULT_SHARE_ZERO_SKIP_EN: a zero operand skips the RUN phase and reports P=0.
module mult_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               En,
  input  logic               Req0,
  input  logic [WIDTH-1:0]   A0,
  input  logic [WIDTH-1:0]   B0,
  input  logic               Req1,
  input  logic [WIDTH-1:0]   A1,
  input  logic [WIDTH-1:0]   B1,
  output logic               Gnt0,
  output logic               Gnt1,
  output logic [2*WIDTH-1:0] P,
  output logic               Done,
  output logic               DoneId,
  output logic               Busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic               owner, owner_nxt;
  logic               last_gnt, last_gnt_nxt;
  logic [2*WIDTH-1:0] p_nxt;
  logic               done_nxt, done_id_nxt, gnt0_nxt, gnt1_nxt;

  logic               winner;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] sum;

  // With both requesting, the side not served most recently wins.
  assign winner = (Req0 && Req1) ? ~last_gnt : Req1;
  assign op_a   = winner ? A1 : A0;
  assign op_b   = winner ? B1 : B0;
  assign sum    = acc + (mplier[0] ? mcand : '0);
  assign Busy   = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      P        <= '0;
      Done     <= 1'b0;
      DoneId   <= 1'b0;
      Gnt0     <= 1'b0;
      Gnt1     <= 1'b0;
    end else if (En) begin
      state    <= state_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      acc      <= acc_nxt;
      count    <= count_nxt;
      owner    <= owner_nxt;
      last_gnt <= last_gnt_nxt;
      P        <= p_nxt;
      Done     <= done_nxt;
      DoneId   <= done_id_nxt;
      Gnt0     <= gnt0_nxt;
      Gnt1     <= gnt1_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mcand_nxt    = mcand;
    mplier_nxt   = mplier;
    acc_nxt      = acc;
    count_nxt    = count;
    owner_nxt    = owner;
    last_gnt_nxt = last_gnt;
    p_nxt        = P;
    done_nxt     = 1'b0;
    done_id_nxt  = DoneId;
    gnt0_nxt     = 1'b0;
    gnt1_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          owner_nxt    = winner;
          last_gnt_nxt = winner;
          gnt0_nxt     = ~winner;
          gnt1_nxt     = winner;
          mcand_nxt    = {{WIDTH{1'b0}}, op_a};
          mplier_nxt   = op_b;
          acc_nxt      = '0;
          count_nxt    = '0;
          state_nxt    = RUN;
`ifdef MULT_SHARE_ZERO_SKIP_EN
          if (op_a == '0 || op_b == '0)
            state_nxt = DONE;
`endif
        end
      end

      RUN: begin
        acc_nxt    = sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          p_nxt       = sum;
          done_nxt    = 1'b1;
          done_id_nxt = owner;
          state_nxt   = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
`ifdef MULT_SHARE_ZERO_SKIP_EN
        // Arrival without a Done pulse means the zero-skip path; report it now.
        if (!Done) begin
          p_nxt       = '0;
          done_nxt    = 1'b1;
          done_id_nxt = owner;
        end
`endif
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: grants push expected results, Done pulses pop and compare.
module tb_mult_share_ctrl;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Reset, En, Req0, Req1;
  logic [W-1:0] A0, B0, A1, B1;
  logic         Gnt0, Gnt1, Done, DoneId, Busy;
  logic [2*W-1:0] P;

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int en_edges = 0;
  bit edge_en = 1'b0;
  int last_gnt_cyc = 0;
  int last_done_cyc = 0;

  typedef struct {
    logic [2*W-1:0] p;
    logic           id;
    int             due;
  } exp_t;

  exp_t sb[$];

  mult_share_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .En(En),
    .Req0(Req0), .A0(A0), .B0(B0),
    .Req1(Req1), .A1(A1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .P(P),
    .Done(Done), .DoneId(DoneId), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (En && !Reset) en_edges <= en_edges + 1;
    edge_en <= En && !Reset;
  end

  // Monitor: samples mid-cycle, only after an edge that could have changed outputs.
  always @(negedge Clk) begin : monitor
    exp_t e;
    logic [2*W-1:0] ax, bx;
    if (edge_en) begin
      if (Gnt0 || Gnt1) begin
        checkOutput("gnt_exclusive", {31'd0, Gnt0 & Gnt1}, 32'd0);
        ax = Gnt1 ? {{W{1'b0}}, A1} : {{W{1'b0}}, A0};
        bx = Gnt1 ? {{W{1'b0}}, B1} : {{W{1'b0}}, B0};
        e.p  = ax * bx;
        e.id = Gnt1;
`ifdef MULT_SHARE_ZERO_SKIP_EN
        e.due = en_edges + ((ax == 0 || bx == 0) ? 1 : W);
`else
        e.due = en_edges + W;
`endif
        sb.push_back(e);
        last_gnt_cyc = cyc;
      end
      if (Done) begin
        if (sb.size() == 0) begin
          checkOutput("done_spurious", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("product", {24'd0, P}, {24'd0, e.p});
          checkOutput("done_id", {31'd0, DoneId}, {31'd0, e.id});
          checkOutput("done_latency", en_edges, e.due);
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic resetDut();
    Reset = 1'b1;
    tick();
    tick();
    sb.delete();
    Reset = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitGrant(output logic id);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    id = 1'b0;
    while (!got && n < 60) begin
      tick();
      n++;
      if (Gnt0 || Gnt1) begin
        got = 1'b1;
        id  = Gnt1;
      end
    end
    if (!got) checkOutput("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic port, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit got;
    if (port) begin A1 = a; B1 = b; Req1 = 1'b1; end
    else      begin A0 = a; B0 = b; Req0 = 1'b1; end
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      tick();
      n++;
      got = port ? Gnt1 : Gnt0;
    end
    if (!got) checkOutput("apply_gnt_timeout", 32'd0, 32'd1);
    if (port) Req1 = 1'b0;
    else      Req0 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic id;
    int prev, rel_cyc, g_cyc;
    logic [W-1:0] t3a[4], t3b[4];
    t3a = '{4'd2, 4'd13, 4'd6, 4'd9};
    t3b = '{4'd3, 4'd14, 4'd7, 4'd11};

    Reset = 1'b1; En = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    tick();
    checkOutput("rst_p", {24'd0, P}, 32'd0);
    checkOutput("rst_done", {31'd0, Done}, 32'd0);
    checkOutput("rst_done_id", {31'd0, DoneId}, 32'd0);
    checkOutput("rst_gnt0", {31'd0, Gnt0}, 32'd0);
    checkOutput("rst_gnt1", {31'd0, Gnt1}, 32'd0);
    checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
    tick();
    Reset = 1'b0;

    // 1: single op 7*9 with Busy dropping one cycle after Done.
    applyStimulus(1'b0, 4'd7, 4'd9);
    checkOutput("t1_busy_run", {31'd0, Busy}, 32'd1);
    waitIdle();
    checkOutput("t1_busy_done", {31'd0, Busy}, 32'd1);
    tick();
    checkOutput("t1_busy_idle", {31'd0, Busy}, 32'd0);

    // 2: simultaneous requests after reset; requester 0 goes first.
    resetDut();
    A0 = 4'd15; B0 = 4'd15; A1 = 4'd3; B1 = 4'd5;
    Req0 = 1'b1; Req1 = 1'b1;
    waitGrant(id);
    checkOutput("t2_first_id", {31'd0, id}, 32'd0);
    Req0 = 1'b0;
    waitGrant(id);
    checkOutput("t2_second_id", {31'd0, id}, 32'd1);
    Req1 = 1'b0;
    waitIdle();

    // 3: both held for four ops; strict alternation, grants 6 cycles apart.
    resetDut();
    A0 = t3a[0]; B0 = t3b[0]; A1 = t3a[1]; B1 = t3b[1];
    Req0 = 1'b1; Req1 = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      waitGrant(id);
      checkOutput("t3_order", {31'd0, id}, i % 2);
      if (i > 0) checkOutput("t3_spacing", last_gnt_cyc - prev, W + 2);
      prev = last_gnt_cyc;
      if (i + 2 < 4) begin
        if (id) begin A1 = t3a[i+2]; B1 = t3b[i+2]; end
        else    begin A0 = t3a[i+2]; B0 = t3b[i+2]; end
      end else begin
        if (id) begin A1 = 4'd1; B1 = 4'd1; end
        else    begin A0 = 4'd1; B0 = 4'd1; end
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    waitIdle();

    // 4: three disabled cycles mid-RUN stretch the latency by exactly three.
    applyStimulus(1'b0, 4'd12, 4'd11);
    g_cyc = last_gnt_cyc;
    tick();
    En = 1'b0;
    tick(); tick(); tick();
    En = 1'b1;
    waitIdle();
    checkOutput("t4_stall_latency", last_done_cyc - g_cyc, W + 3);
    checkOutput("t4_p_hold", {24'd0, P}, 32'd132);

    // 5: reset mid-RUN drops the op; held Req1 wins the first edge after release.
    applyStimulus(1'b0, 4'd3, 4'd3);
    A1 = 4'd2; B1 = 4'd5; Req1 = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    checkOutput("t5_async_p", {24'd0, P}, 32'd0);
    checkOutput("t5_async_busy", {31'd0, Busy}, 32'd0);
    checkOutput("t5_async_done", {31'd0, Done}, 32'd0);
    checkOutput("t5_async_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);
    sb.delete();
    tick();
    tick();
    Reset = 1'b0;
    rel_cyc = cyc;
    waitGrant(id);
    checkOutput("t5_regrant_id", {31'd0, id}, 32'd1);
    checkOutput("t5_regrant_edge", last_gnt_cyc - rel_cyc, 32'd1);
    Req1 = 1'b0;
    waitIdle();

    // 6: exhaustive sweep on port 0.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        applyStimulus(1'b0, W'(a), W'(b));
        waitIdle();
      end
    end

    repeat (8) tick();
    checkOutput("final_queue_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Round-robin controller that shares one iterative shift-add unsigned multiplier between two requesters.
- Each requester presents operands with a request and receives a grant pulse when its operands are latched.
- The block sequences the WIDTH-cycle multiply, then returns the product with a done pulse and requester ID.
- Sits between the two client blocks and the multiply datapath; holds the datapath internally so arbitration and sequencing are verified as one unit.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  asynchronous, active-high reset.
En  in  1  clock enable; low freezes all state and registered outputs.
Req0  in  1  requester 0 request; held high until Gnt0 is seen.
A0  in  WIDTH  requester 0 multiplicand.
B0  in  WIDTH  requester 0 multiplier.
Req1  in  1  requester 1 request.
A1  in  WIDTH  requester 1 multiplicand.
B1  in  WIDTH  requester 1 multiplier.
Gnt0  out  1  one-cycle pulse: A0/B0 latched.
Gnt1  out  1  one-cycle pulse: A1/B1 latched.
P  out  2*WIDTH  product of the last completed operation.
Done  out  1  one-cycle pulse: P valid, new value.
DoneId  out  1  requester that owns P (0 or 1).
Busy  out  1  high whenever the FSM is not in IDLE (decoded from state register).

Behaviour:
- Reset (async, dominates En and everything else):
  - State → IDLE.
  - P=0, Done=0, DoneId=0, Gnt0=Gnt1=0, Busy=0.
  - Internal accumulator and counter cleared.
  - Round-robin pointer set so requester 0 wins first.
- En=0: no state, counter, accumulator or output register changes. A Done or Gnt pulse in flight stays high until the next enabled edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - On an edge with Req0|Req1 → latch the winner's A/B, clear the accumulator, set count=0, pulse that Gnt, → RUN.
    - No request → stay in IDLE.
  - RUN: each enabled edge does one shift-add iteration.
    - If the multiplier LSB is 1, accumulator += multiplicand shifted left by count.
    - Multiplier shifts right; count increments.
    - On the WIDTH-th RUN edge, load the final sum into P, Done=1, DoneId=owner → DONE.
  - DONE: next enabled edge sets Done=0 → IDLE. No grant is issued from DONE.
- Latency, grant edge = e0:
  - Gnt high during e0→e1.
  - Done high during e(WIDTH)→e(WIDTH+1); for WIDTH=4, Done follows edge e4.
  - Next grant no earlier than edge e(WIDTH+2). Throughput is one op per WIDTH+2 cycles.
- Arbitration:
  - Only one requester high → it wins.
  - Both high → the requester not granted most recently wins. The pointer updates only on a grant.
- Requests:
  - Req is sampled only in IDLE.
  - Req changes in RUN/DONE are ignored.
  - Operand changes after the grant edge do not affect the result.
- Arithmetic: unsigned only; full 2*WIDTH result, never truncated; max (2^WIDTH-1)^2 fits.
- P holds its value between Done pulses.
- Gnt0 and Gnt1 are never high together.
- Reset mid-RUN drops the operation: no Done for it, no Gnt replay. A request held through reset is granted on the first enabled edge after reset release.

Optional Feature:
MULT_SHARE_ZERO_SKIP_EN
- Defined: if the latched A or B equals 0, the grant edge goes directly to DONE with P=0.
  - Done follows edge e1.
  - Next grant no earlier than e2.
- Undefined: zero operands take the full WIDTH RUN cycles, like any other operands.

Test Plan:
1. Reset, then Req0=1, A0=7, B0=9 → Gnt0 pulse after e0; Done after e4 with P=63, DoneId=0; Busy low again after e5.
2. Req0 and Req1 both raised the same cycle, A0=15, B0=15, A1=3, B1=5 → Gnt0 first, P=225/DoneId=0; then Gnt1, P=15/DoneId=1; never both Gnt high.
3. Req0 and Req1 held high for 4 operations → grant order 0,1,0,1; each P correct; grants spaced exactly 6 cycles apart.
4. En forced low for 3 cycles mid-RUN with A0=12, B0=11 → Done delayed exactly 3 cycles versus an unstalled run; P=132.
5. Reset pulsed after e2 of an op → all outputs 0 immediately (asynchronously); no Done for the dropped op; held Req1 then granted first after release.
6. Exhaustive sweep of A0, B0 over 0..15 on port 0 → P==A0*B0 at every Done, 0 errors. With MULT_SHARE_ZERO_SKIP_EN defined, every zero-operand case shows Done at e1.
